// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM bus arbiter.
// State encodings, bus widths and the captured bus command bundle.
package mem_bus_arbiter_pkg;

  localparam int RegBus      = 32;
  localparam int InstAddrBus = 32;
  localparam int DefTimeout  = 255;
  localparam int DefCntW     = 10;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbIfBusy  = 2'd1,
    ArbMemBusy = 2'd2,
    ArbDone    = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic                   we;
    logic [3:0]             sel;
    logic [InstAddrBus-1:0] addr;
    logic [RegBus-1:0]      wdata;
  } bus_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts busy cycles and flags the last allowed one.
// Cleared when a transaction is accepted, advanced while busy.
module mem_bus_arbiter_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires on the TIMEOUT-th busy cycle, so bus_req lasts TIMEOUT cycles.
  assign timeout_o = enable_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port bus arbiter between instruction fetch and the MEM stage.
// MEM has priority; fetches can be flushed; a watchdog ends stuck cycles.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DefTimeout,
  parameter int CNT_W   = DefCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   if_req_i,
  input  logic [InstAddrBus-1:0] if_addr_i,
  output logic                   if_ready_o,
  output logic [RegBus-1:0]      if_data_o,
  output logic                   if_err_o,
  input  logic                   mem_req_i,
  input  logic                   mem_we_i,
  input  logic [3:0]             mem_sel_i,
  input  logic [InstAddrBus-1:0] mem_addr_i,
  input  logic [RegBus-1:0]      mem_wdata_i,
  output logic                   mem_ready_o,
  output logic [RegBus-1:0]      mem_rdata_o,
  output logic                   mem_err_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [3:0]             bus_sel_o,
  output logic [InstAddrBus-1:0] bus_addr_o,
  output logic [RegBus-1:0]      bus_wdata_o,
  input  logic                   bus_ack_i,
  input  logic [RegBus-1:0]      bus_rdata_i,
  output logic                   busy_o
);

  arb_state_e        state_q, state_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              drop_q, drop_d;
  logic              bus_req_q, bus_req_d;
  logic              busy_q, busy_d;
  logic              if_ready_q, if_ready_d;
  logic              if_err_q, if_err_d;
  logic [RegBus-1:0] if_data_q, if_data_d;
  logic              mem_ready_q, mem_ready_d;
  logic              mem_err_q, mem_err_d;
  logic [RegBus-1:0] mem_rdata_q, mem_rdata_d;
  logic              wd_clear, wd_en, wd_to;

  mem_bus_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .timeout_o (wd_to)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    if_ready_d  = 1'b0;
    if_err_d    = if_err_q;
    if_data_d   = if_data_q;
    mem_ready_d = 1'b0;
    mem_err_d   = mem_err_q;
    mem_rdata_d = mem_rdata_q;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        drop_d = 1'b0;
        if (mem_req_i) begin
          cmd_d = '{we: mem_we_i, sel: mem_sel_i,
                    addr: mem_addr_i, wdata: mem_wdata_i};
          bus_req_d = 1'b1;
          wd_clear  = 1'b1;
          state_d   = ArbMemBusy;
        end else if (if_req_i && !flush_i) begin
          cmd_d.we   = 1'b0;
          cmd_d.sel  = 4'hF;
          cmd_d.addr = if_addr_i;
          bus_req_d  = 1'b1;
          wd_clear   = 1'b1;
          state_d    = ArbIfBusy;
        end
      end
      ArbIfBusy: begin
        wd_en = 1'b1;
        if (flush_i) drop_d = 1'b1;
        if (bus_ack_i || wd_to) begin
          bus_req_d = 1'b0;
          state_d   = ArbDone;
          // A flushed fetch still finishes on the bus but is not reported.
          if (!(drop_q || flush_i)) begin
            if_ready_d = 1'b1;
            if_err_d   = !bus_ack_i;
            if_data_d  = bus_ack_i ? bus_rdata_i : '0;
          end
        end
      end
      ArbMemBusy: begin
        wd_en = 1'b1;
        if (bus_ack_i || wd_to) begin
          bus_req_d   = 1'b0;
          state_d     = ArbDone;
          mem_ready_d = 1'b1;
          mem_err_d   = !bus_ack_i;
          mem_rdata_d = bus_ack_i ? bus_rdata_i : '0;
        end
      end
      ArbDone: begin
        drop_d  = 1'b0;
        state_d = ArbIdle;
      end
      default: state_d = ArbIdle;
    endcase
    busy_d = (state_d != ArbIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      cmd_q       <= '0;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_data_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      busy_q      <= busy_d;
      if_ready_q  <= if_ready_d;
      if_err_q    <= if_err_d;
      if_data_q   <= if_data_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = cmd_q.we;
  assign bus_sel_o   = cmd_q.sel;
  assign bus_addr_o  = cmd_q.addr;
  assign bus_wdata_o = cmd_q.wdata;
  assign busy_o      = busy_q;
  assign if_ready_o  = if_ready_q;
  assign if_err_o    = if_err_q;
  assign if_data_o   = if_data_q;
  assign mem_ready_o = mem_ready_q;
  assign mem_err_o   = mem_err_q;
  assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: bus responder model plus completion scoreboard.
// Scenario tasks run in sequence; a monitor pops and checks each ready pulse.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_data_o;
  logic        if_err_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        busy_o;

  mem_bus_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ready_o  (if_ready_o),
    .if_data_o   (if_data_o),
    .if_err_o    (if_err_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_sel_i   (mem_sel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_ready_o (mem_ready_o),
    .mem_rdata_o (mem_rdata_o),
    .mem_err_o   (mem_err_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_sel_o   (bus_sel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  bit   ack_en    = 1'b1;
  int   ack_delay = 0;
  bit   stray     = 1'b0;
  int   wcnt      = 0;

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h100) return 32'h24020005;
    return {a[15:0] ^ 16'hA5A5, a[31:16] ^ 16'h5A5A};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0BAD0BAD;
    forever begin
      @(negedge clk);
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'h0BAD0BAD;
      if (bus_req_o === 1'b1) begin
        if (ack_en && wcnt == ack_delay) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = model(bus_addr_o);
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
      if (stray) bus_ack_i = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] gd;
    logic        ge;
    if (rst === 1'b0 && (if_ready_o === 1'b1 || mem_ready_o === 1'b1)) begin
      total_cnt++;
      if (if_ready_o === 1'b1 && mem_ready_o === 1'b1) begin
        $display("FAIL ready_overlap: if_ready=1 mem_ready=1, required at most one");
      end else if (q.size() == 0) begin
        $display("FAIL unexpected_ready: if_ready=%b mem_ready=%b, required none",
                 if_ready_o, mem_ready_o);
      end else begin
        e  = q.pop_front();
        gd = if_ready_o ? if_data_o : mem_rdata_o;
        ge = if_ready_o ? if_err_o : mem_err_o;
        if (if_ready_o !== e.is_if || gd !== e.data || ge !== e.err)
          $display("FAIL completion: is_if=%b data=%h err=%b, required is_if=%b data=%h err=%b",
                   if_ready_o, gd, ge, e.is_if, e.data, e.err);
        else pass_cnt++;
      end
    end
  end

  task automatic wait_bus_req(input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_req_o === level) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input bit is_if, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((is_if ? if_ready_o : mem_ready_o) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_i = 0; if_req_i = 0; if_addr_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_sel_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus_req_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL reset_req_busy: bus_req=%b busy=%b, required 0 0", bus_req_o, busy_o);
    else pass_cnt++;
    total_cnt++;
    if (if_ready_o !== 1'b0 || mem_ready_o !== 1'b0 || if_err_o !== 1'b0 || mem_err_o !== 1'b0)
      $display("FAIL reset_ready: if_ready=%b mem_ready=%b if_err=%b mem_err=%b, required 0",
               if_ready_o, mem_ready_o, if_err_o, mem_err_o);
    else pass_cnt++;
    total_cnt++;
    if (bus_sel_o !== 4'h0 || bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || bus_we_o !== 1'b0)
      $display("FAIL reset_bus: sel=%h addr=%h wdata=%h we=%b, required 0",
               bus_sel_o, bus_addr_o, bus_wdata_o, bus_we_o);
    else pass_cnt++;
    total_cnt++;
    if (if_data_o !== 32'h0 || mem_rdata_o !== 32'h0)
      $display("FAIL reset_data: if_data=%h mem_rdata=%h, required 0", if_data_o, mem_rdata_o);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    bit ok;
    ack_en = 1; ack_delay = 1;
    q.push_back('{1'b1, 32'h24020005, 1'b0});
    if_req_i = 1; if_addr_i = 32'h100;
    wait_bus_req(1'b1, ok);
    total_cnt++;
    if (!ok || bus_addr_o !== 32'h100 || bus_sel_o !== 4'hF || bus_we_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL fetch_bus: ok=%b addr=%h sel=%h we=%b busy=%b, required 1 00000100 f 0 1",
               ok, bus_addr_o, bus_sel_o, bus_we_o, busy_o);
    else pass_cnt++;
    wait_ready(1'b1, ok);
    total_cnt++;
    if (!ok) $display("FAIL fetch_ready: no if_ready within bound, required pulse");
    else pass_cnt++;
    if_req_i = 0;
    @(negedge clk);
    total_cnt++;
    if (if_ready_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL fetch_pulse: if_ready=%b busy=%b, required 0 0", if_ready_o, busy_o);
    else pass_cnt++;
  endtask

  task automatic test_priority;
    bit ok;
    ack_en = 1; ack_delay = 0;
    q.push_back('{1'b0, model(32'h80), 1'b0});
    q.push_back('{1'b1, model(32'h200), 1'b0});
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h80; mem_wdata_i = 32'hDEADBEEF;
    if_req_i = 1; if_addr_i = 32'h200;
    wait_bus_req(1'b1, ok);
    total_cnt++;
    if (!ok || bus_we_o !== 1'b1 || bus_sel_o !== 4'b0011 ||
        bus_addr_o !== 32'h80 || bus_wdata_o !== 32'hDEADBEEF)
      $display("FAIL prio_mem_bus: ok=%b we=%b sel=%h addr=%h wdata=%h, required 1 1 3 00000080 deadbeef",
               ok, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o);
    else pass_cnt++;
    wait_ready(1'b0, ok);
    total_cnt++;
    if (!ok) $display("FAIL prio_mem_ready: no mem_ready within bound, required pulse");
    else pass_cnt++;
    mem_req_i = 0; mem_we_i = 0;
    wait_bus_req(1'b1, ok);
    total_cnt++;
    if (!ok || bus_addr_o !== 32'h200 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF)
      $display("FAIL prio_if_bus: ok=%b addr=%h we=%b sel=%h, required 1 00000200 0 f",
               ok, bus_addr_o, bus_we_o, bus_sel_o);
    else pass_cnt++;
    wait_ready(1'b1, ok);
    total_cnt++;
    if (!ok) $display("FAIL prio_if_ready: no if_ready within bound, required pulse");
    else pass_cnt++;
    if_req_i = 0;
    @(negedge clk);
  endtask

  task automatic test_flush;
    bit ok;
    ack_en = 1; ack_delay = 3;
    if_req_i = 1; if_addr_i = 32'h300;
    wait_bus_req(1'b1, ok);
    flush_i = 1; if_addr_i = 32'h80000180;
    q.push_back('{1'b1, model(32'h80000180), 1'b0});
    @(negedge clk);
    flush_i = 0;
    wait_bus_req(1'b0, ok);
    total_cnt++;
    if (!ok || if_ready_o !== 1'b0 || if_data_o !== model(32'h200) || if_err_o !== 1'b0)
      $display("FAIL flush_drop: ok=%b if_ready=%b if_data=%h if_err=%b, required 1 0 %h 0",
               ok, if_ready_o, if_data_o, if_err_o, model(32'h200));
    else pass_cnt++;
    wait_bus_req(1'b1, ok);
    total_cnt++;
    if (!ok || bus_addr_o !== 32'h80000180)
      $display("FAIL flush_refetch: ok=%b addr=%h, required 1 80000180", ok, bus_addr_o);
    else pass_cnt++;
    wait_ready(1'b1, ok);
    total_cnt++;
    if (!ok) $display("FAIL flush_ready: no if_ready within bound, required pulse");
    else pass_cnt++;
    if_req_i = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    ack_en = 0;
    q.push_back('{1'b0, 32'h0, 1'b1});
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h40;
    wait_bus_req(1'b1, ok);
    n = 0;
    while (bus_req_o === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    total_cnt++;
    if (!ok || n != 8)
      $display("FAIL timeout_len: ok=%b busy_cycles=%0d, required 1 8", ok, n);
    else pass_cnt++;
    total_cnt++;
    if (mem_ready_o !== 1'b1)
      $display("FAIL timeout_ready: mem_ready=%b, required 1", mem_ready_o);
    else pass_cnt++;
    mem_req_i = 0;
    @(negedge clk);
    stray = 1;
    repeat (2) @(negedge clk);
    stray = 0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy_o !== 1'b0 || bus_req_o !== 1'b0 || mem_rdata_o !== 32'h0)
      $display("FAIL stray_ack: busy=%b bus_req=%b mem_rdata=%h, required 0 0 0",
               busy_o, bus_req_o, mem_rdata_o);
    else pass_cnt++;
    ack_en = 1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    ack_en = 0;
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h44;
    wait_bus_req(1'b1, ok);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    total_cnt++;
    if (!ok || bus_req_o !== 1'b0 || busy_o !== 1'b0 || mem_ready_o !== 1'b0)
      $display("FAIL rst_mid: ok=%b bus_req=%b busy=%b mem_ready=%b, required 1 0 0 0",
               ok, bus_req_o, busy_o, mem_ready_o);
    else pass_cnt++;
    ack_en = 1; ack_delay = 1;
    q.push_back('{1'b0, model(32'h44), 1'b0});
    rst = 0;
    wait_bus_req(1'b1, ok);
    total_cnt++;
    if (!ok || bus_addr_o !== 32'h44)
      $display("FAIL rst_reissue: ok=%b addr=%h, required 1 00000044", ok, bus_addr_o);
    else pass_cnt++;
    wait_ready(1'b0, ok);
    total_cnt++;
    if (!ok) $display("FAIL rst_ready: no mem_ready within bound, required pulse");
    else pass_cnt++;
    mem_req_i = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok;
    int last;
    logic [31:0] addrs [4];
    addrs = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    ack_en = 1; ack_delay = 0;
    foreach (addrs[k]) q.push_back('{1'b1, model(addrs[k]), 1'b0});
    if_req_i = 1; if_addr_i = addrs[0];
    last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ready(1'b1, ok);
      total_cnt++;
      if (!ok)
        $display("FAIL b2b_ready: fetch %0d got no if_ready, required pulse", i);
      else if (i > 0 && cyc - last != 3)
        $display("FAIL b2b_spacing: fetch %0d spacing=%0d, required 3", i, cyc - last);
      else pass_cnt++;
      last = cyc;
      if (i < 3) if_addr_i = addrs[i+1];
      else if_req_i = 0;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    total_cnt++;
    if (q.size() != 0)
      $display("FAIL scoreboard_drain: pending=%0d, required 0", q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
